// File: rtl/muxn_arb_pkg.sv
// rtl/muxn_arb_pkg.sv - shared mode encodings and select-width helper for muxn_arb
package muxn_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A single channel still needs a one-bit select/source field.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/muxn_arb_rr_pick.sv
// rtl/muxn_arb_rr_pick.sv - combinational rotate-priority picker starting at ptr
module rr_pick #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    valid,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] pick,
    output logic            pick_valid
);

    logic [N-1:0] rot;
    logic [SELW:0] sum;

    always_comb begin
        // Rotate so that bit 0 of rot is channel ptr, then take the lowest set offset.
        rot        = N'({valid, valid} >> ptr);
        pick_valid = |rot;
        sum        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (SELW + 1)'(k);
            end
        end
        if (sum >= (SELW + 1)'(N)) begin
            sum = sum - (SELW + 1)'(N);
        end
        pick = sum[SELW-1:0];
    end

endmodule

// File: rtl/muxn_arb.sv
// rtl/muxn_arb.sv - N-input registered mux with fixed/round-robin grant; MUXN_ARB_HOLD_EN adds channel lock
module muxn_arb
    import muxn_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N-1:0]       in_hold,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  rr_g;
    logic             rr_gv;
    logic [SELW-1:0]  g;
    logic             gv;
    logic [SELW-1:0]  g_next;
    logic [N-1:0]     grant_oh;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;

`ifdef MUXN_ARB_HOLD_EN
    logic             locked;
    logic [SELW-1:0]  lock_ch;
    logic             hold_hit;
`else
    logic             unused_hold;
    assign unused_hold = ^in_hold;
`endif

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_pick (
        .valid      (in_valid),
        .ptr        (ptr),
        .pick       (rr_g),
        .pick_valid (rr_gv)
    );

    assign load = !out_valid || out_ready;

    always_comb begin
        g  = sel;
        gv = ({1'b0, sel} < (SELW + 1)'(N));
        if (mode == MODE_RR) begin
            g  = rr_g;
            gv = rr_gv;
`ifdef MUXN_ARB_HOLD_EN
            // A locked channel keeps the grant even while it has nothing to send.
            if (locked) begin
                g  = lock_ch;
                gv = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        grant_oh = '0;
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            grant_oh[i] = gv && (g == SELW'(i));
            if (grant_oh[i]) begin
                mux_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = (load && !reset) ? grant_oh : '0;
    assign xfer     = |(in_valid & in_ready);
    assign g_next   = (g == SELW'(N - 1)) ? '0 : g + SELW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUXN_ARB_HOLD_EN
    assign hold_hit = |(in_hold & grant_oh);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (mode == MODE_FIXED) begin
            locked <= 1'b0;
        end else if (xfer) begin
            if (hold_hit) begin
                locked  <= 1'b1;
                lock_ch <= g;
            end else begin
                locked <= 1'b0;
                ptr    <= g_next;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (mode == MODE_RR && xfer) begin
            ptr <= g_next;
        end
    end
`endif

endmodule

// File: tb/tb_muxn_arb.sv
// tb/tb_muxn_arb.sv - randomized reference-model bench for muxn_arb
module tb_muxn_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   in_hold;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;

    logic [1:0]     sel3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_ready3;
    logic [2:0]     in_hold3;
    logic [3*W-1:0] in_data3;
    logic           out_valid3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_src3;

    int checks   = 0;
    int failures = 0;

    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_src;
    int         m_ptr;
    bit         m_lock;
    int         m_lock_ch;

    logic [N-1:0] pre_ready;
    logic [2:0]   pre_ready3;

    muxn_arb #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_hold   (in_hold),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    muxn_arb #(.WIDTH(W), .N(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_hold   (in_hold3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_data  (out_data3),
        .out_src   (out_src3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_grant(output int g, output bit gv);
        int c;
        g  = 0;
        gv = 0;
        if (mode == 1'b0) begin
            g  = int'(sel);
            gv = (int'(sel) < N);
        end else if (m_lock) begin
            g  = m_lock_ch;
            gv = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!gv && in_valid[c]) begin
                    g  = c;
                    gv = 1;
                end
            end
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic step();
        int         g;
        bit         gv;
        bit         x;
        logic [N-1:0] er;
        #2;
        model_grant(g, gv);
        er = (!reset && (!m_valid || out_ready) && gv) ? N'(1 << g) : '0;
        x  = (er & in_valid) != 0;
        pre_ready  = in_ready;
        pre_ready3 = in_ready3;
        check("in_ready", in_ready, er);
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0; m_lock = 0;
        end else begin
            if (x) begin
                m_valid = 1;
                m_data  = in_data[g*W +: W];
                m_src   = g;
            end else if (out_ready) begin
                m_valid = 0;
            end
`ifdef MUXN_ARB_HOLD_EN
            if (mode == 1'b0) begin
                m_lock = 0;
            end else if (x) begin
                if (in_hold[g]) begin
                    m_lock = 1; m_lock_ch = g;
                end else begin
                    m_lock = 0; m_ptr = (g + 1) % N;
                end
            end
`else
            if (mode == 1'b1 && x) m_ptr = (g + 1) % N;
`endif
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_src", out_src, m_src);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    endtask

    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] saved;

    initial begin
        m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0; m_lock = 0; m_lock_ch = 0;
        reset = 1; mode = 1'b1; sel = '0; in_valid = '1; in_hold = '0; out_ready = 1'b1;
        sel3 = '0; in_valid3 = '0; in_hold3 = '0; in_data3 = '0;
        rand_data();

        repeat (2) begin
            step();
            check("rst_ready", pre_ready, 0);
        end
        reset = 0;

        mode = 1'b0; sel = 2; in_valid = 4'b0100; in_data[2*W +: W] = 32'hDEADBEEF; sel3 = 3;
        step();
        check("fix_ready", pre_ready, 4'b0100);
        check("fix_data", out_data, 32'hDEADBEEF);
        check("fix_src", out_src, 2);
        check("n3_oob_ready", pre_ready3, 0);
        sel3 = 1;
        step();
        check("n3_sel1_ready", pre_ready3, 3'b010);
        check("n3_idle", out_valid3, 0);

        mode = 1'b1; in_valid = '1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step();
            check($sformatf("rr_src%0d", i), out_src, exp_seq[i]);
        end

        out_ready = 0;
        saved = m_data;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
            check("bp_ready", pre_ready, 0);
            check("bp_data", out_data, saved);
        end
        out_ready = 1; in_valid = 4'b0010;
        step();
        check("refill_src", out_src, 1);
        check("refill_valid", out_valid, 1);

        out_ready = 0; in_valid = '1;
        step();
        reset = 1;
        step();
        check("midrst_valid", out_valid, 0);
        reset = 0; out_ready = 1;
        step();
        check("midrst_rr_src", out_src, 0);

`ifdef MUXN_ARB_HOLD_EN
        in_valid = 4'b0111;
        in_hold = 4'b0010; step(); check("hold_src0", out_src, 1);
        in_hold = 4'b0010; step(); check("hold_src1", out_src, 1);
        in_hold = 4'b0000; step(); check("hold_src2", out_src, 1);
        step(); check("hold_after", out_src, 2);
`endif

        repeat (400) begin
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sel       = SW'($urandom);
            in_valid  = N'($urandom);
            in_hold   = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            rand_data();
            step();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
